// File: rtl/instr_rom_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : instr_rom_sync                                              |
// | Description : Clocked instruction memory for the 8-bit CPU. One-cycle     |
// |               registered fetch with a valid/ready handshake toward the    |
// |               decode stage, plus an optional program-load write port.     |
// | Options     : ROM_LOAD_EN - when defined, load_* writes program words;    |
// |               when undefined, load_* is ignored and the memory is a ROM.  |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module instr_rom_sync #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16   // implemented words, DEPTH <= 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              addr_err,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data
);

  // Full decode of the address space; rows at or above DEPTH read as zero.
  localparam int ROWS = 2 ** ADDR_W;

  // Power-up program image, zero-extended or truncated to DATA_W.
  function automatic logic [DATA_W-1:0] boot_word(input int idx);
    logic [7:0] b;
    case (idx)
      0:       b = 8'h10;
      1:       b = 8'h20;
      2:       b = 8'h30;
      default: b = 8'h00;
    endcase
    return DATA_W'(b);
  endfunction

  logic [DATA_W-1:0] w_table [ROWS];
  logic [DATA_W-1:0] w_rd_data;
  logic              w_oob;
  logic              w_accept;
  logic [DATA_W-1:0] r_instr;
  logic              r_valid;
  logic              r_err;

  // One storage (or constant) cell per implemented word.
  for (genvar i = 0; i < ROWS; i++) begin : g_row
    if (i < DEPTH) begin : g_word
`ifdef ROM_LOAD_EN
      // Power-up value comes from the image; reset deliberately leaves it alone
      // so that a loaded program survives a CPU reset.
      logic [DATA_W-1:0] r_word = boot_word(i);

      // Program-load write. The fetch path samples the pre-edge value, which
      // gives read-before-write when load and fetch hit the same word.
      always_ff @(posedge clk) begin
        if (load_en && (load_addr == ADDR_W'(i))) begin
          r_word <= load_data;
        end
      end

      assign w_table[i] = r_word;
`else
      assign w_table[i] = boot_word(i);
`endif
    end else begin : g_hole
      assign w_table[i] = '0;
    end
  end

`ifndef ROM_LOAD_EN
  // The load port stays on the interface but has no effect in the ROM build.
  logic w_load_unused;
  assign w_load_unused = ^{load_en, load_addr, load_data};
`endif

  // Address range check done in ADDR_W+1 bits so DEPTH == 2**ADDR_W still fits.
  assign w_oob       = ({1'b0, fetch_addr} >= (ADDR_W + 1)'(DEPTH));
  assign w_rd_data   = w_oob ? '0 : w_table[fetch_addr];

  // A new word may enter when the output slot is empty or being drained.
  assign fetch_ready = !r_valid || instr_ready;
  assign w_accept    = fetch_req && fetch_ready;

  // Output slot: capture on accept, drop valid on a pure consume, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_instr <= w_rd_data;
      r_valid <= 1'b1;
      r_err   <= w_oob;
    end else if (instr_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign instr       = r_instr;
  assign instr_valid = r_valid;
  assign addr_err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_instr_rom_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_instr_rom_sync                                           |
// | Description : Directed, table-driven bench for instr_rom_sync (DEPTH=12). |
// |               Expectations for load behaviour follow ROM_LOAD_EN.         |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module tb_instr_rom_sync;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DP = 12;

`ifdef ROM_LOAD_EN
  localparam logic [DW-1:0] LD0 = 8'hFF;
  localparam logic [DW-1:0] LD5 = 8'hA5;
`else
  localparam logic [DW-1:0] LD0 = 8'h10;
  localparam logic [DW-1:0] LD5 = 8'h00;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          fetch_req = 1'b0;
  logic [AW-1:0] fetch_addr = '0;
  logic          fetch_ready;
  logic [DW-1:0] instr;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic          addr_err;
  logic          load_en = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [DW-1:0] load_data = '0;

  int total = 0;
  int bad   = 0;

  instr_rom_sync #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_ready(fetch_ready),
    .instr      (instr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .addr_err   (addr_err),
    .load_en    (load_en),
    .load_addr  (load_addr),
    .load_data  (load_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         tag;
    logic          req;
    logic [AW-1:0] addr;
    logic          rdy;
    logic          ld;
    logic [AW-1:0] laddr;
    logic [DW-1:0] ldata;
    logic          exp_fr;
    logic          exp_v;
    logic [DW-1:0] exp_ins;
    logic          exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic add(input string tag, input logic req, input logic [AW-1:0] addr,
                     input logic rdy, input logic ld, input logic [AW-1:0] laddr,
                     input logic [DW-1:0] ldata, input logic fr, input logic v,
                     input logic [DW-1:0] ins, input logic err);
    vec_t t;
    t.tag = tag; t.req = req; t.addr = addr; t.rdy = rdy; t.ld = ld;
    t.laddr = laddr; t.ldata = ldata; t.exp_fr = fr; t.exp_v = v;
    t.exp_ins = ins; t.exp_err = err;
    vecs.push_back(t);
  endtask

  // Drive one cycle of inputs and clock it, ending 1 time unit after the edge.
  task automatic cyc(input logic req, input logic [AW-1:0] addr, input logic rdy);
    fetch_req = req; fetch_addr = addr; instr_ready = rdy; load_en = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //   tag            req addr rdy ld laddr ldata  fr v  ins    err
    add("b2b0",         1, 0,  1, 0, 0, 8'h00, 1, 1, 8'h10, 0);
    add("b2b1",         1, 1,  1, 0, 0, 8'h00, 1, 1, 8'h20, 0);
    add("b2b2",         1, 2,  1, 0, 0, 8'h00, 1, 1, 8'h30, 0);
    add("drain",        0, 0,  1, 0, 0, 8'h00, 1, 0, 8'h30, 0);
    add("stall_acc1",   1, 1,  0, 0, 0, 8'h00, 1, 1, 8'h20, 0);
    add("stall_c1",     1, 2,  0, 0, 0, 8'h00, 0, 1, 8'h20, 0);
    add("stall_c2",     1, 2,  0, 0, 0, 8'h00, 0, 1, 8'h20, 0);
    add("stall_c3",     1, 2,  0, 0, 0, 8'h00, 0, 1, 8'h20, 0);
    add("stall_rel",    1, 2,  1, 0, 0, 8'h00, 1, 1, 8'h30, 0);
    add("drain2",       0, 0,  1, 0, 0, 8'h00, 1, 0, 8'h30, 0);
    add("oob13",        1, 13, 1, 0, 0, 8'h00, 1, 1, 8'h00, 1);
    add("oob_hold",     0, 0,  0, 0, 0, 8'h00, 0, 1, 8'h00, 1);
    add("after_oob",    1, 0,  1, 0, 0, 8'h00, 1, 1, 8'h10, 0);
    add("drain3",       0, 0,  1, 0, 0, 8'h00, 1, 0, 8'h10, 0);
    add("ld0",          0, 0,  1, 1, 0, 8'hFF, 1, 0, 8'h10, 0);
    add("fetch0_ld",    1, 0,  1, 0, 0, 8'h00, 1, 1, LD0,   0);
    add("ld5_raw",      1, 5,  1, 1, 5, 8'hA5, 1, 1, 8'h00, 0);
    add("refetch5",     1, 5,  1, 0, 0, 8'h00, 1, 1, LD5,   0);
    add("ld_oob",       0, 0,  1, 1, 13, 8'h5A, 1, 0, LD5,  0);
    add("fetch13",      1, 13, 1, 0, 0, 8'h00, 1, 1, 8'h00, 1);
    add("fetch1_alias", 1, 1,  1, 0, 0, 8'h00, 1, 1, 8'h20, 0);
    add("drain4",       0, 0,  1, 0, 0, 8'h00, 1, 0, 8'h20, 0);

    // Power-on reset, then check the reset state of the outputs.
    #1 rst_n = 1'b0;
    #2;
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_instr", instr, 8'h00);
    chk("rst_err",   addr_err, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (vecs[k]) begin
      fetch_req = vecs[k].req; fetch_addr = vecs[k].addr; instr_ready = vecs[k].rdy;
      load_en = vecs[k].ld; load_addr = vecs[k].laddr; load_data = vecs[k].ldata;
      #1;
      chk({vecs[k].tag, ".fetch_ready"}, fetch_ready, vecs[k].exp_fr);
      @(posedge clk);
      #1;
      chk({vecs[k].tag, ".instr_valid"}, instr_valid, vecs[k].exp_v);
      chk({vecs[k].tag, ".instr"},       instr,       vecs[k].exp_ins);
      chk({vecs[k].tag, ".addr_err"},    addr_err,    vecs[k].exp_err);
    end
    load_en = 1'b0;

    // Pulse reset: loaded words must survive it.
    cyc(0, 0, 1);
    rst_n = 1'b0;
    #2;
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(1, 5, 1);
    chk("post_rst_fetch5", instr, LD5);
    chk("post_rst_valid",  instr_valid, 1'b1);
    cyc(0, 0, 1);

    // Asynchronous reset mid-cycle while a word is stalled in the slot.
    cyc(1, 1, 0);
    chk("pre_async_valid", instr_valid, 1'b1);
    chk("pre_async_instr", instr, 8'h20);
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", instr_valid, 1'b0);
    chk("async_instr", instr, 8'h00);
    chk("async_err",   addr_err, 1'b0);

    // No accept while reset is held, even with a request present.
    cyc(1, 2, 1);
    chk("rst_hold_valid", instr_valid, 1'b0);
    chk("rst_hold_instr", instr, 8'h00);
    rst_n = 1'b1;
    cyc(1, 2, 1);
    chk("recover_valid", instr_valid, 1'b1);
    chk("recover_instr", instr, 8'h30);
    cyc(0, 0, 1);
    chk("final_drain", instr_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_rom_sync.md
Name: instr_rom_sync

Overview:
Parametrised, clocked instruction memory for the 8-bit CPU, replacing the combinational 16x8 program ROM. It provides a registered fetch path with a valid/ready handshake toward the decode stage, so the fetch unit can stall. It also provides an optional program-load write port so a bootloader or testbench can rewrite program words without re-elaborating the design.

Parameters:
- DATA_W, 8, instruction word width in bits.
- ADDR_W, 4, fetch/load address width.
- DEPTH, 16, number of implemented words; must satisfy DEPTH <= 2**ADDR_W.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- fetch_req  in  1  fetch request; fetch_addr is valid while this is high.
- fetch_addr  in  ADDR_W  word address to fetch (program counter).
- fetch_ready  out  1  high when a request will be accepted this cycle.
- instr  out  DATA_W  registered instruction word.
- instr_valid  out  1  instr holds an unconsumed word.
- instr_ready  in  1  consumer accepts instr this cycle.
- addr_err  out  1  registered flag: the word in instr came from an address >= DEPTH.
- load_en  in  1  program-load write strobe.
- load_addr  in  ADDR_W  program-load word address.
- load_data  in  DATA_W  program-load write data.

Behaviour:
- Reset (rst_n low, asynchronous): instr=0, instr_valid=0, addr_err=0. Memory contents are NOT cleared; loaded words survive reset.
- Power-up contents: word 0 = 0x10, word 1 = 0x20, word 2 = 0x30 (zero-extended or truncated to DATA_W); all other words 0.
- fetch_ready = !instr_valid || instr_ready (combinational).
- Accept: fetch_req && fetch_ready at a rising edge.
  - Next cycle: instr=mem[fetch_addr], instr_valid=1.
  - Latency is exactly 1 cycle, request to valid.
- Consume without new accept (instr_valid && instr_ready && !fetch_req): instr_valid goes to 0. instr holds its last value.
- Back-to-back: accept and consume in the same cycle gives one word per cycle, with instr_valid staying 1.
- Stall (instr_valid && !instr_ready):
  - instr and addr_err hold stable.
  - fetch_ready=0; a fetch_req in this cycle is ignored, and the requester must hold it.
- Out of range (fetch_addr >= DEPTH): the accept still completes with instr=0 and addr_err=1. addr_err updates on every accept and holds during a stall.
- Load write: load_en at the edge writes load_data to mem[load_addr].
  - Writes with load_addr >= DEPTH are dropped silently.
  - Loads are independent of the fetch handshake.
- Load and fetch to the same address in the same cycle: read-before-write. instr returns the old word; the new word is visible to the next fetch.
- Reset asserted mid-stall drops the pending word. No fetch is accepted while rst_n is low.

Optional Feature:
- Macro: ROM_LOAD_EN.
- Defined: load port functional as described above.
- Undefined: load_* ports remain on the interface but are ignored. Memory is read-only with the power-up contents, and synthesises as ROM.

Test Plan:
- Reset then fetch addr 0,1,2 back-to-back with instr_ready=1 -> instr = 0x10, 0x20, 0x30 on consecutive cycles after a 1-cycle latency; instr_valid continuously 1.
- Fetch addr 1, hold instr_ready=0 for 3 cycles with fetch_req=1 addr 2 -> fetch_ready=0, instr stays 0x20 for 3 cycles. Raise instr_ready -> next cycle instr=0x30.
- DEPTH=12, fetch addr 13 -> instr=0, addr_err=1. Following fetch of addr 0 -> addr_err=0, instr=0x10.
- ROM_LOAD_EN defined: load 0xA5 to addr 5 while fetching addr 5 in the same cycle -> instr=0x00. Refetch addr 5 -> 0xA5. Pulse rst_n, refetch -> still 0xA5.
- ROM_LOAD_EN undefined: load 0xFF to addr 0, then fetch addr 0 -> instr=0x10.
- Assert rst_n low asynchronously mid-cycle while instr_valid=1 -> instr_valid=0 and instr=0 immediately, with no clock edge required.
